// File: rtl/pi_scroll_ctrl.sv
// pi_scroll_ctrl: sequencing controller for the pi-digit scroller.
// Owns the digit ROM read port, fetches an 8-digit window into a shadow
// buffer and commits it to the display in a single cycle.
// Optional feature: define PI_SCROLL_REVERSE_EN to add the dir port and
// reverse scrolling with underflow wrap (0 -> MAXN).
module pi_scroll_ctrl #(
  parameter int ROM_LAT     = 1,
  parameter int MAXN        = 82936,
  parameter int TICK_PERIOD = 33554432,
  parameter int ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              step,
`ifdef PI_SCROLL_REVERSE_EN
  input  logic              dir,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [31:0]       digits,
  output logic [ADDR_W-1:0] base,
  output logic              frame_valid,
  output logic              busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int              TW       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [TW-1:0]   TICK_MAX = TW'(TICK_PERIOD - 1);
  localparam logic [ADDR_W-1:0] BASE_MAX = ADDR_W'(MAXN);

  logic [1:0]        r_state;
  logic [TW-1:0]     r_tick;
  logic              r_pend;
  logic              r_fill;
  logic [2:0]        r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_digits;
  logic              r_fv;
  // Slot 7 is never stored: it is taken straight from rom_data at commit.
  logic [3:0]        r_shadow [7];
  logic [ROM_LAT:1]  r_vld_pipe;
  logic [2:0]        r_idx_pipe [ROM_LAT:1];

  logic              w_tick;
  logic              w_evt;
  logic              w_start;
  logic              w_cap;
  logic              w_last;
  logic [2:0]        w_cap_idx;
  logic [ADDR_W-1:0] w_next_base;
  logic [31:0]       w_window;

  assign w_tick    = !pause && (r_tick == TICK_MAX);
  assign w_evt     = step || w_tick;
  assign w_start   = (r_state == S_IDLE) && (w_evt || r_pend || r_fill);
  assign w_cap     = r_vld_pipe[ROM_LAT];
  assign w_cap_idx = r_idx_pipe[ROM_LAT];
  assign w_last    = w_cap && (w_cap_idx == 3'd7);

  assign rom_addr    = r_addr;
  assign digits      = r_digits;
  assign base        = r_base;
  assign frame_valid = r_fv;
  assign busy        = (r_state != S_IDLE);

  // Base to use for the next fetch; a fill refetches the current base.
  always_comb begin
    w_next_base = (r_base == BASE_MAX) ? '0 : r_base + ADDR_W'(1);
`ifdef PI_SCROLL_REVERSE_EN
    if (dir) w_next_base = (r_base == '0) ? BASE_MAX : r_base - ADDR_W'(1);
`endif
    if (r_fill) w_next_base = r_base;
  end

  // Full window as it will be committed: stored slots 0..6 plus the slot-7 digit arriving now.
  always_comb begin
    w_window = '0;
    for (int k = 0; k < 7; k++) w_window[4*k +: 4] = r_shadow[k];
    w_window[31:28] = rom_data;
  end

  // Auto-advance tick counter; frozen by pause, free-running while busy.
  always_ff @(posedge clk) begin
    if (rst) r_tick <= '0;
    else if (!pause) r_tick <= (r_tick == TICK_MAX) ? '0 : r_tick + TW'(1);
  end

  // Tag pipeline tracking which slot each in-flight ROM read belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int k = 1; k <= ROM_LAT; k++) r_idx_pipe[k] <= '0;
    end else begin
      r_vld_pipe[1] <= (r_state == S_FETCH);
      r_idx_pipe[1] <= r_idx;
      for (int k = 2; k <= ROM_LAT; k++) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_idx_pipe[k] <= r_idx_pipe[k-1];
      end
    end
  end

  // Shadow capture of returning ROM digits (slots 0..6).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) r_shadow[k] <= '0;
    end else if (w_cap && (w_cap_idx != 3'd7)) begin
      r_shadow[w_cap_idx] <= rom_data;
    end
  end

  // Sequencing FSM: start fetch, issue 8 addresses, wait for last digit, commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_fill   <= 1'b1;
      r_pend   <= 1'b0;
      r_idx    <= '0;
      r_base   <= '0;
      r_addr   <= '0;
      r_digits <= '0;
      r_fv     <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_base  <= w_next_base;
            r_addr  <= w_next_base;
            r_idx   <= '0;
            // An event coinciding with the fill is kept for afterwards.
            r_pend  <= r_fill && w_evt;
            r_fill  <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_evt) r_pend <= 1'b1;
          if (r_idx == 3'd7) begin
            r_state <= S_DRAIN;
          end else begin
            r_idx  <= r_idx + 3'd1;
            r_addr <= r_base + ADDR_W'(r_idx) + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (w_evt) r_pend <= 1'b1;
          if (w_last) begin
            r_digits <= w_window;
            r_fv     <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/pi_scroll_ctrl.md
# pi_scroll_ctrl

Sequencing controller for the pi-digit scroller. It owns the single read port of the pi digit ROM and decides when the scroll window advances. On each advance it fetches the 8-digit window into a shadow buffer, then commits all 8 digits to the display driver in one cycle, so the display never shows a half-updated window. It sits between the pi digit ROM (read latency `ROM_LAT`) and the 8-digit display driver.

## Interface
- `ROM_LAT`, 1: ROM read latency in cycles, from address to data (legal range 1..3).
- `MAXN`, 82936: highest legal window base; the ROM holds `MAXN+8` digits.
- `TICK_PERIOD`, 33554432: clock cycles between automatic advances.
- `ADDR_W`, 17: ROM address width.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `pause` in 1: when 1, the auto-advance tick counter holds its value.
- `step` in 1: single-cycle pulse requesting one advance; accepted whether or not `pause` is set.
- `dir` in 1: 0 = forward, 1 = reverse. Present only with `PI_SCROLL_REVERSE_EN`.
- `rom_addr` out `ADDR_W`: registered ROM read address.
- `rom_data` in 4: ROM digit, valid `ROM_LAT` cycles after `rom_addr`.
- `digits` out 32: committed window; digit i is at `[4i+3:4i]`; digit 0 is at `base`.
- `base` out `ADDR_W`: window base of the window now being fetched or committed.
- `frame_valid` out 1: one-cycle pulse in the cycle a new window appears on `digits`.
- `busy` out 1: high in `FETCH`/`DRAIN`.

## Operation
- **FSM states:** `IDLE`, `FETCH`, `DRAIN`.
- **Reset values:**
  - `digits`, `base`, `rom_addr`, tick counter, pending flag, fetch index: 0.
  - `frame_valid`, `busy`: 0.
  - State: `IDLE`, with an internal "fill" request set.
- **Advance event:** tick counter wrap, or `step`=1. A fill request is also an event, but it does not move `base`.
- **Advance arithmetic:**
  - Forward: `base` ← (`base`==`MAXN`) ? 0 : `base`+1.
  - Reverse: `base` ← (`base`==0) ? `MAXN` : `base`−1.
  - `base` is updated on the same edge that enters `FETCH`.
- **Tick counter:**
  - Counts 0..`TICK_PERIOD`−1, wraps to 0, and produces an event on the wrap cycle.
  - Frozen while `pause`=1; it keeps counting while `busy`.
- **IDLE:**
  - Any event, or the pending flag: apply the advance (unless this is a fill), clear pending/fill, set fetch index to 0, go to `FETCH`.
  - Pending has priority; a new event arriving in the same cycle is merged into it (one advance total).
- **FETCH:**
  - Drives `rom_addr` = `base` + i for i = 0..7, one per cycle.
  - Addresses never wrap; max is `MAXN`+7.
  - After i=7, go to `DRAIN`.
- **Capture:**
  - A `ROM_LAT`-deep pipeline of (valid, index) tags follows the issued addresses.
  - When a tag emerges, `rom_data` is written into shadow slot index.
- **DRAIN:**
  - Waits until the last tag (index 7) captures.
  - On that edge: copy shadow (including the slot-7 data) to `digits`, pulse `frame_valid`, go to `IDLE`.
- **Events while `busy`:** set the pending flag (1 deep). Any number of events collapse to exactly one further advance.
- **`dir` sampling:** sampled when the advance is applied, not when the event occurs.
- **`rst` mid-fetch:** aborts the fetch immediately. Shadow contents are discarded, `digits` returns to 0, and the initial fill at `base` 0 starts again.

## Timing
- Event in `IDLE` at cycle T → `FETCH` and new `base` from T+1.
- `rom_addr` for index i is presented during cycle T+1+i.
- Slot i is captured at the end of cycle T+1+i+`ROM_LAT`.
- `digits` updated and `frame_valid`=1 in cycle T+9+`ROM_LAT`; with `ROM_LAT`=1 this is 10 cycles after the event.
- `busy`=1 for cycles T+1 .. T+8+`ROM_LAT`; in `IDLE` again at T+9+`ROM_LAT`.
- A pending advance starts `FETCH` in the cycle after `frame_valid`. Back-to-back frames are therefore 9+`ROM_LAT` cycles apart.
- Initial fill: first cycle with `rst`=0 counts as T.
- Minimum `TICK_PERIOD` is 12. Smaller values produce continuous pending-driven refresh, which is legal but not a supported configuration.

## Configuration
- `PI_SCROLL_REVERSE_EN` defined:
  - `dir` port exists.
  - Reverse advance and underflow wrap (0 → `MAXN`) are implemented.
- `PI_SCROLL_REVERSE_EN` undefined:
  - `dir` port is absent.
  - Every advance is forward; no decrement logic is built.

## Test plan
- **Reset fill:** release `rst` with ROM model = pi digits, `ROM_LAT`=1. Expect `frame_valid` exactly 10 cycles later, `digits` = 3,1,4,1,5,9,2,6 (digit 0 first), `base`=0.
- **Tick advance:** `TICK_PERIOD`=64, `pause`=0. Expect `frame_valid` with `base`=1 and `digits` = 1,4,1,5,9,2,6,5.
- **Pause and step:**
  - Hold `pause`=1 for 1000 cycles: no `frame_valid`.
  - Pulse `step` once: `base` increments by exactly 1, frame arrives 10 cycles later.
  - Release `pause`: the tick counter resumes from its frozen value.
- **Pending collapse:** three `step` pulses during one fetch. Expect exactly two frames, `base` 1 then 2, the second starting the cycle after the first `frame_valid`.
- **Wrap and reverse:**
  - Force `base`=`MAXN`, forward step: `base`=0.
  - With `PI_SCROLL_REVERSE_EN`, `dir`=1, step from 0: `base`=`MAXN`, and `rom_addr` spans `MAXN`..`MAXN`+7.
- **Reset mid-fetch:** assert `rst` for 1 cycle during `FETCH` of `base`=5. Expect `digits`=0, no partial frame, then a full fill at `base`=0 (3,1,4,1,5,9,2,6). Repeat with `ROM_LAT`=3: latency 12 cycles.
